// File: rtl/ahb_lite_master.sv
// Single-outstanding AHB-Lite master: turns one client request into one SINGLE
// transfer (address phase, data phase) and returns a one-cycle response strobe.
module ahb_lite_master #(
    parameter logic [3:0] HPROT_VAL = 4'b0011
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic        HMASTLOCK,
    output logic [31:0] HWDATA,
    input  logic        HREADY,
    input  logic [31:0] HRDATA,
    input  logic        HRESP
);
    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;
    state_t state;

    logic        misaligned;
    logic [31:0] wlanes;
    logic [31:0] rd_shift;
    logic [31:0] rd_ext;

    assign HBURST    = 3'b000;
    assign HPROT     = HPROT_VAL;
    assign HMASTLOCK = 1'b0;

    always_comb begin
        misaligned = 1'b0;
        wlanes     = req_wdata;
        case (req_size)
            3'd0: wlanes = {4{req_wdata[7:0]}};
            3'd1: begin
                wlanes     = {2{req_wdata[15:0]}};
                misaligned = req_addr[0];
            end
            3'd2: misaligned = (req_addr[1:0] != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

    // HADDR/HSIZE still hold the latched request during the data phase.
    always_comb begin
        rd_shift = HRDATA >> {HADDR[1:0], 3'b000};
        case (HSIZE)
            3'd0:    rd_ext = {24'h0, rd_shift[7:0]};
            3'd1:    rd_ext = {16'h0, rd_shift[15:0]};
            default: rd_ext = rd_shift;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= S_IDLE;
            req_ready <= 1'b0;
            HTRANS    <= TR_IDLE;
            HADDR     <= 32'h0;
            HWRITE    <= 1'b0;
            HSIZE     <= 3'd0;
            HWDATA    <= 32'h0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        if (misaligned) begin
                            // rejected without touching the bus
                            state     <= S_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= 32'h0;
                        end else begin
                            state  <= S_ADDR;
                            HTRANS <= TR_NONSEQ;
                            HADDR  <= req_addr;
                            HWRITE <= req_write;
                            HSIZE  <= req_size;
                            HWDATA <= wlanes;
                        end
                    end
                end
                S_ADDR: begin
                    if (HREADY) begin
                        state  <= S_DATA;
                        HTRANS <= TR_IDLE;
                    end
                end
                S_DATA: begin
                    if (HREADY) begin
                        state     <= S_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= HRESP;
                        rsp_rdata <= (HRESP || HWRITE) ? 32'h0 : rd_ext;
                    end
                end
                S_RESP: begin
                    state     <= S_IDLE;
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed bench for ahb_lite_master: inputs driven and outputs sampled on the
// falling edge, one task per scenario with hand-computed expectations.
module tb_ahb_lite_master;
    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [2:0]  req_size = 3'd0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HMASTLOCK;
    logic [31:0] HWDATA;
    logic        HREADY = 1'b1;
    logic [31:0] HRDATA = 32'h0;
    logic        HRESP = 1'b0;

    int total = 0;
    int bad = 0;

    always #5 HCLK = ~HCLK;

    ahb_lite_master #(.HPROT_VAL(4'b0011)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
        .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP)
    );

    task automatic issue(input logic wr, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_size = sz; req_wdata = wd;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge HCLK);
        total++;
        if ({req_ready, HTRANS, HADDR, HWRITE, HSIZE, HWDATA, rsp_valid, rsp_err, rsp_rdata} !== 104'h0) begin
            bad++; $display("FAIL reset_outputs: got rdy=%b tr=%b a=%h w=%b sz=%0d wd=%h rv=%b re=%b rd=%h, want all zero",
                req_ready, HTRANS, HADDR, HWRITE, HSIZE, HWDATA, rsp_valid, rsp_err, rsp_rdata);
        end
        total++;
        if ({HBURST, HPROT, HMASTLOCK} !== {3'b000, 4'b0011, 1'b0}) begin
            bad++; $display("FAIL reset_constants: got burst=%b prot=%b lock=%b, want 000 0011 0", HBURST, HPROT, HMASTLOCK);
        end
        HRESETn = 1'b1;
        @(negedge HCLK);
        total++;
        if (req_ready !== 1'b1) begin
            bad++; $display("FAIL reset_release_ready: got %b want 1", req_ready);
        end
    endtask

    task automatic test_word_write();
        HREADY = 1'b1;
        issue(1'b1, 32'h100, 3'd2, 32'hDEADBEEF);
        @(negedge HCLK);
        total++;
        if ({HTRANS, HADDR, HWRITE, HSIZE, req_ready} !== {2'b10, 32'h100, 1'b1, 3'd2, 1'b0}) begin
            bad++; $display("FAIL ww_addr_phase: got tr=%b a=%h w=%b sz=%0d rdy=%b, want 10 100 1 2 0", HTRANS, HADDR, HWRITE, HSIZE, req_ready);
        end
        // a different request held valid must be ignored while busy
        issue(1'b0, 32'h500, 3'd2, 32'h0);
        @(negedge HCLK);
        total++;
        if ({HTRANS, HWDATA, rsp_valid, HADDR} !== {2'b00, 32'hDEADBEEF, 1'b0, 32'h100}) begin
            bad++; $display("FAIL ww_data_phase: got tr=%b wd=%h rv=%b a=%h, want 00 deadbeef 0 100", HTRANS, HWDATA, rsp_valid, HADDR);
        end
        req_valid = 1'b0;
        @(negedge HCLK);
        total++;
        if ({rsp_valid, rsp_err, rsp_rdata, req_ready} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
            bad++; $display("FAIL ww_resp: got rv=%b re=%b rd=%h rdy=%b, want 1 0 0 0", rsp_valid, rsp_err, rsp_rdata, req_ready);
        end
        @(negedge HCLK);
        total++;
        if ({rsp_valid, req_ready, HTRANS} !== {1'b0, 1'b1, 2'b00}) begin
            bad++; $display("FAIL ww_back_idle: got rv=%b rdy=%b tr=%b, want 0 1 00", rsp_valid, req_ready, HTRANS);
        end
    endtask

    task automatic test_byte_read_wait();
        HREADY = 1'b1;
        issue(1'b0, 32'h203, 3'd0, 32'h0);
        @(negedge HCLK);
        req_valid = 1'b0;
        total++;
        if ({HTRANS, HADDR, HWRITE, HSIZE} !== {2'b10, 32'h203, 1'b0, 3'd0}) begin
            bad++; $display("FAIL br_addr_phase: got tr=%b a=%h w=%b sz=%0d, want 10 203 0 0", HTRANS, HADDR, HWRITE, HSIZE);
        end
        @(negedge HCLK);
        HREADY = 1'b0; HRDATA = 32'h12345678;
        for (int i = 0; i < 2; i++) begin
            @(negedge HCLK);
            total++;
            if ({rsp_valid, HTRANS} !== {1'b0, 2'b00}) begin
                bad++; $display("FAIL br_wait%0d: got rv=%b tr=%b, want 0 00", i, rsp_valid, HTRANS);
            end
        end
        HREADY = 1'b1; HRDATA = 32'hAB000000;
        @(negedge HCLK);
        HRDATA = 32'h0;
        total++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'h000000AB}) begin
            bad++; $display("FAIL br_resp: got rv=%b re=%b rd=%h, want 1 0 000000ab", rsp_valid, rsp_err, rsp_rdata);
        end
        @(negedge HCLK);
        total++;
        if ({rsp_valid, rsp_rdata} !== {1'b0, 32'h000000AB}) begin
            bad++; $display("FAIL br_rdata_hold: got rv=%b rd=%h, want 0 000000ab", rsp_valid, rsp_rdata);
        end
    endtask

    task automatic test_half_write_addr_wait();
        HREADY = 1'b0;
        issue(1'b1, 32'h12, 3'd1, 32'hFFFF1234);
        @(negedge HCLK);
        req_valid = 1'b0;
        total++;
        if ({HTRANS, HADDR, HSIZE, HWRITE} !== {2'b10, 32'h12, 3'd1, 1'b1}) begin
            bad++; $display("FAIL hw_addr0: got tr=%b a=%h sz=%0d w=%b, want 10 12 1 1", HTRANS, HADDR, HSIZE, HWRITE);
        end
        @(negedge HCLK);
        total++;
        if ({HTRANS, HADDR, HSIZE, HWRITE} !== {2'b10, 32'h12, 3'd1, 1'b1}) begin
            bad++; $display("FAIL hw_addr_held: got tr=%b a=%h sz=%0d w=%b, want 10 12 1 1", HTRANS, HADDR, HSIZE, HWRITE);
        end
        HREADY = 1'b1;
        @(negedge HCLK);
        total++;
        if ({HTRANS, HWDATA} !== {2'b00, 32'h12341234}) begin
            bad++; $display("FAIL hw_data: got tr=%b wd=%h, want 00 12341234", HTRANS, HWDATA);
        end
        @(negedge HCLK);
        total++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'h0}) begin
            bad++; $display("FAIL hw_resp: got rv=%b re=%b rd=%h, want 1 0 0", rsp_valid, rsp_err, rsp_rdata);
        end
        @(negedge HCLK);
    endtask

    task automatic test_misaligned();
        logic [31:0] addrs [3] = '{32'h102, 32'h101, 32'h100};
        logic [2:0]  sizes [3] = '{3'd2, 3'd1, 3'd3};
        for (int i = 0; i < 3; i++) begin
            HREADY = 1'b1;
            issue(1'b0, addrs[i], sizes[i], 32'h0);
            @(negedge HCLK);
            req_valid = 1'b0;
            total++;
            if ({HTRANS, HADDR, rsp_valid, rsp_err, rsp_rdata, req_ready} !== {2'b00, 32'h12, 1'b1, 1'b1, 32'h0, 1'b0}) begin
                bad++; $display("FAIL mis%0d_resp: got tr=%b a=%h rv=%b re=%b rd=%h rdy=%b, want 00 12 1 1 0 0",
                    i, HTRANS, HADDR, rsp_valid, rsp_err, rsp_rdata, req_ready);
            end
            @(negedge HCLK);
            total++;
            if ({rsp_valid, req_ready, HTRANS} !== {1'b0, 1'b1, 2'b00}) begin
                bad++; $display("FAIL mis%0d_idle: got rv=%b rdy=%b tr=%b, want 0 1 00", i, rsp_valid, req_ready, HTRANS);
            end
        end
    endtask

    task automatic test_reads();
        logic [31:0] addrs [2] = '{32'h32, 32'h44};
        logic [2:0]  sizes [2] = '{3'd1, 3'd2};
        logic [31:0] bus   [2] = '{32'hCAFE1234, 32'h89ABCDEF};
        logic [31:0] exp   [2] = '{32'h0000CAFE, 32'h89ABCDEF};
        for (int i = 0; i < 2; i++) begin
            HREADY = 1'b1;
            issue(1'b0, addrs[i], sizes[i], 32'h0);
            @(negedge HCLK);
            req_valid = 1'b0;
            @(negedge HCLK);
            HRDATA = bus[i];
            @(negedge HCLK);
            HRDATA = 32'h0;
            total++;
            if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, exp[i]}) begin
                bad++; $display("FAIL rd%0d_resp: got rv=%b re=%b rd=%h, want 1 0 %h", i, rsp_valid, rsp_err, rsp_rdata, exp[i]);
            end
            @(negedge HCLK);
        end
    endtask

    task automatic test_error();
        HREADY = 1'b1;
        issue(1'b0, 32'h40, 3'd2, 32'h0);
        @(negedge HCLK);
        req_valid = 1'b0;
        @(negedge HCLK);
        HREADY = 1'b0; HRESP = 1'b1; HRDATA = 32'h55555555;
        @(negedge HCLK);
        total++;
        if ({HTRANS, rsp_valid} !== {2'b00, 1'b0}) begin
            bad++; $display("FAIL err_first: got tr=%b rv=%b, want 00 0", HTRANS, rsp_valid);
        end
        HREADY = 1'b1;
        @(negedge HCLK);
        HRESP = 1'b0; HRDATA = 32'h0;
        total++;
        if ({HTRANS, rsp_valid, rsp_err, rsp_rdata} !== {2'b00, 1'b1, 1'b1, 32'h0}) begin
            bad++; $display("FAIL err_resp: got tr=%b rv=%b re=%b rd=%h, want 00 1 1 0", HTRANS, rsp_valid, rsp_err, rsp_rdata);
        end
        @(negedge HCLK);
    endtask

    task automatic test_reset_mid();
        HREADY = 1'b1;
        issue(1'b1, 32'h80, 3'd2, 32'hA5A5A5A5);
        @(negedge HCLK);
        req_valid = 1'b0;
        @(negedge HCLK);
        HREADY = 1'b0;
        #2 HRESETn = 1'b0;
        #1;
        total++;
        if ({req_ready, HTRANS, HADDR, HWRITE, HSIZE, HWDATA, rsp_valid, rsp_err, rsp_rdata} !== 104'h0) begin
            bad++; $display("FAIL rst_mid_async: got rdy=%b tr=%b a=%h w=%b sz=%0d wd=%h rv=%b re=%b rd=%h, want all zero",
                req_ready, HTRANS, HADDR, HWRITE, HSIZE, HWDATA, rsp_valid, rsp_err, rsp_rdata);
        end
        @(negedge HCLK);
        HREADY = 1'b1;
        HRESETn = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge HCLK);
            total++;
            if ({rsp_valid, req_ready} !== {1'b0, 1'b1}) begin
                bad++; $display("FAIL rst_mid_after%0d: got rv=%b rdy=%b, want 0 1", i, rsp_valid, req_ready);
            end
        end
        issue(1'b0, 32'h8, 3'd2, 32'h0);
        @(negedge HCLK);
        req_valid = 1'b0;
        total++;
        if ({HTRANS, HADDR} !== {2'b10, 32'h8}) begin
            bad++; $display("FAIL rst_mid_next_addr: got tr=%b a=%h, want 10 8", HTRANS, HADDR);
        end
        @(negedge HCLK);
        HRDATA = 32'h11223344;
        @(negedge HCLK);
        total++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'h11223344}) begin
            bad++; $display("FAIL rst_mid_next_resp: got rv=%b re=%b rd=%h, want 1 0 11223344", rsp_valid, rsp_err, rsp_rdata);
        end
        @(negedge HCLK);
    endtask

    initial begin
        test_reset();
        test_word_write();
        test_byte_read_wait();
        test_half_write_addr_wait();
        test_misaligned();
        test_reads();
        test_error();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ahb_lite_master.md
AHB_LITE_MASTER -- requirements
Module: ahb_lite_master

Interface
REQ-001 SHALL have parameter HPROT_VAL, default 4'b0011, HPROT value driven on every transfer.
REQ-002 SHALL have ports, clock and reset first:
- HCLK  in  1  clock, all state on rising edge
- HRESETn  in  1  reset; one clock; reset is asynchronous and active-low
- req_valid  in  1  client request valid
- req_ready  out  1  request accepted when valid&ready at rising edge
- req_write  in  1  1=write, 0=read
- req_addr  in  32  byte address
- req_size  in  3  AHB HSIZE encoding (0=byte, 1=half, 2=word)
- req_wdata  in  32  write data, right-justified
- rsp_valid  out  1  one-cycle response strobe
- rsp_rdata  out  32  read data, right-justified, zero-extended
- rsp_err  out  1  1=error response or misaligned request
- HADDR  out  32  AHB address
- HTRANS  out  2  IDLE=2'b00, NONSEQ=2'b10 only
- HWRITE  out  1  AHB direction
- HSIZE  out  3  AHB size
- HBURST  out  3  constant 3'b000 (SINGLE)
- HPROT  out  4  constant HPROT_VAL
- HMASTLOCK  out  1  constant 0
- HWDATA  out  32  AHB write data
- HREADY  in  1  bus ready
- HRDATA  in  32  AHB read data
- HRESP  in  1  0=OKAY, 1=ERROR

Function
REQ-003 SHALL implement states IDLE, ADDR, DATA, RESP; at most one transfer outstanding.
REQ-004 SHALL drive req_ready=1 only in IDLE.
REQ-005 Accept in IDLE: aligned request -> latch addr/size/write/wdata, go ADDR; misaligned (half with addr[0]=1, word with addr[1:0]!=0, size>2) -> go RESP with rsp_err=1, no bus activity.
REQ-006 ADDR: HTRANS=NONSEQ, HADDR/HWRITE/HSIZE from latched request; held stable until rising edge with HREADY=1, then go DATA.
REQ-007 DATA: HTRANS=IDLE; HWDATA held stable for the whole data phase; rising edge with HREADY=1 ends phase -> RESP, capture HRDATA and HRESP.
REQ-008 ERROR: HRESP=1 with HREADY=0 SHALL keep HTRANS=IDLE; completion edge (HREADY=1, HRESP=1) -> rsp_err=1, rsp_rdata=0.
REQ-009 RESP: rsp_valid=1 for exactly one cycle, then IDLE; req_ready=0 in RESP.
REQ-010 Latency, zero-wait slave: accept at edge N -> NONSEQ cycle N..N+1 -> data phase N+1..N+2 -> rsp_valid during cycle after edge N+2; each HREADY=0 cycle adds one.
REQ-011 Write lanes: byte -> req_wdata[7:0] replicated ×4; half -> req_wdata[15:0] replicated ×2; word -> as-is.
REQ-012 Read extract: rsp_rdata = HRDATA >> (8*addr[1:0]), masked to 8/16/32 bits by size, zero-extended.
REQ-013 rsp_rdata SHALL be 0 for writes and error responses; holds value until next rsp_valid.
REQ-014 Outside ADDR: HADDR/HWRITE/HSIZE hold last value; HTRANS=IDLE.
REQ-015 req_* inputs SHALL be ignored in all states except IDLE.

Reset
REQ-016 HRESETn low SHALL asynchronously force state=IDLE, HTRANS=IDLE, HADDR=0, HWRITE=0, HSIZE=0, HWDATA=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, req_ready=0 while asserted.
REQ-017 Reset during ADDR or DATA SHALL abandon the transfer with no response; req_ready=1 on first cycle after deassertion.

Verification
REQ-018 Word write 0x100=0xDEADBEEF, zero-wait -> one NONSEQ cycle HADDR=0x100 HWRITE=1 HSIZE=2; next cycle HWDATA=0xDEADBEEF; rsp_valid one cycle, rsp_err=0.
REQ-019 Byte read 0x203, HRDATA=0xAB000000, 2 wait states in data phase -> rsp_rdata=0x000000AB, rsp_valid 2 cycles later than zero-wait.
REQ-020 Half write 0x12 data 0x1234 -> HWDATA=0x12341234, HSIZE=1; HREADY=0 during address phase holds HADDR/HTRANS stable.
REQ-021 Word read 0x102 -> no NONSEQ issued; rsp_valid next cycle with rsp_err=1.
REQ-022 Two-cycle ERROR (HRESP=1/HREADY=0 then HRESP=1/HREADY=1) on read -> HTRANS stays IDLE, rsp_err=1, rsp_rdata=0.
REQ-023 HRESETn low mid data phase -> all outputs at reset values immediately; no rsp_valid; next request completes normally.
